// File: rtl/board_cursor_ctrl.sv
// board_cursor_ctrl
// Owns the 4x4 board register file, the cursor and whose-turn state for the
// cell-select/empty-check block. It drives the consumer's cell and counter
// inputs and uses the consumer's empty flag to accept or reject placements.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   move_next, move_prev  one-cycle pulses, cursor +1 / -1 (wrapping 0..15)
//   place                 one-cycle pulse, request a token at the cursor
//   clear                 one-cycle pulse, wipe board and restart the game
//   empty_i               consumer's empty flag for the cell at counter_o
//   counter_o[7:0]        cursor index, upper nibble always 0
//   cells_o[63:0]         board, cell k at bits [4k+3:4k]
//   player_o              0 = player 1 to move, 1 = player 2
//   place_ok, place_err   one-cycle result pulses of a placement
//   move_count[4:0]       tokens placed (0..16), board_full when 16
//   timeout_o             one-cycle pulse on a forced turn pass
//
// Optional feature: define TURN_TIMEOUT_EN to add the idle-turn timeout
// (TIMEOUT_CYC idle cycles pass the turn). Without it timeout_o is tied 0.
module board_cursor_ctrl #(
  parameter logic [3:0]  EMPTY_CODE  = 4'b0000,
  parameter logic [3:0]  P1_CODE     = 4'b0001,
  parameter logic [3:0]  P2_CODE     = 4'b0010,
  parameter logic [31:0] TIMEOUT_CYC = 32'd50_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        move_next,
  input  logic        move_prev,
  input  logic        place,
  input  logic        clear,
  input  logic        empty_i,
  output logic [7:0]  counter_o,
  output logic [63:0] cells_o,
  output logic        player_o,
  output logic        place_ok,
  output logic        place_err,
  output logic [4:0]  move_count,
  output logic        board_full,
  output logic        timeout_o
);

  typedef enum logic [1:0] {IDLE, CHECK, WRITE, REJECT} state_t;

  state_t      state, state_n;
  logic [3:0]  cells [16];
  logic [3:0]  cursor;
  logic        timeout_hit;

  assign counter_o  = {4'b0000, cursor};
  assign board_full = (move_count == 5'd16);

  always_comb begin
    cells_o = '0;
    for (int unsigned k = 0; k < 16; k++) begin
      cells_o[4*k +: 4] = cells[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // A clear in WRITE aborts the write, so the ok pulse is withheld too.
  always_comb begin
    state_n   = state;
    place_ok  = 1'b0;
    place_err = 1'b0;
    case (state)
      IDLE:    if (place) state_n = CHECK;
      CHECK:   state_n = (empty_i && !board_full) ? WRITE : REJECT;
      WRITE: begin
        place_ok = !clear;
        state_n  = IDLE;
      end
      REJECT: begin
        place_err = 1'b1;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (clear) state_n = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < 16; k++) cells[k] <= EMPTY_CODE;
      cursor     <= '0;
      player_o   <= 1'b0;
      move_count <= '0;
    end else if (clear) begin
      for (int unsigned k = 0; k < 16; k++) cells[k] <= EMPTY_CODE;
      cursor     <= '0;
      player_o   <= 1'b0;
      move_count <= '0;
    end else begin
      if (state == IDLE && !place && (move_next ^ move_prev)) begin
        cursor <= move_next ? cursor + 4'd1 : cursor - 4'd1;
      end
      if (state == WRITE) begin
        cells[cursor] <= player_o ? P2_CODE : P1_CODE;
        player_o      <= ~player_o;
        if (move_count != 5'd16) move_count <= move_count + 5'd1;
      end else if (timeout_hit) begin
        player_o <= ~player_o;
      end
    end
  end

`ifdef TURN_TIMEOUT_EN
  logic [31:0] idle_cnt;

  // A place or clear in the same cycle wins over the forced pass.
  assign timeout_hit = (state == IDLE) && !clear && !place && !board_full &&
                       (idle_cnt == TIMEOUT_CYC - 32'd1);
  assign timeout_o   = timeout_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (clear || timeout_hit || state_n == CHECK) begin
      idle_cnt <= '0;
    end else if (state == IDLE && !board_full) begin
      idle_cnt <= idle_cnt + 32'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_o   = 1'b0;
`endif

endmodule

// File: tb/tb_board_cursor_ctrl.sv
module tb_board_cursor_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        move_next = 1'b0, move_prev = 1'b0, place = 1'b0, clear = 1'b0;
  logic        empty_i = 1'b0;
  logic [7:0]  counter_o;
  logic [63:0] cells_o;
  logic        player_o, place_ok, place_err, board_full, timeout_o;
  logic [4:0]  move_count;

  always #5 clk = ~clk;

  board_cursor_ctrl #(.TIMEOUT_CYC(32'd8)) dut (
    .clk(clk), .rst_n(rst_n), .move_next(move_next), .move_prev(move_prev),
    .place(place), .clear(clear), .empty_i(empty_i), .counter_o(counter_o),
    .cells_o(cells_o), .player_o(player_o), .place_ok(place_ok),
    .place_err(place_err), .move_count(move_count), .board_full(board_full),
    .timeout_o(timeout_o)
  );

  typedef struct {
    bit          ok;
    logic [63:0] cells;
    bit          player;
    logic [4:0]  cnt;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          tcount = 0;

  logic [3:0]  m_cells [16];
  logic [3:0]  m_cursor;
  bit          m_player;
  int          m_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] m_pack();
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < 16; k++) v[4*k +: 4] = m_cells[k];
    return v;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 16; k++) m_cells[k] = 4'h0;
    m_cursor = 4'd0;
    m_player = 1'b0;
    m_cnt    = 0;
  endtask

  // Monitor: every result pulse must match the next expected entry; the
  // board/player/count are compared on the cycle after the pulse, once the
  // write has landed.
  always @(negedge clk) begin
    if (rst_n && (place_ok || place_err)) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {place_ok, place_err}, 2'b00);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result_kind", {place_ok, place_err}, e.ok ? 2'b10 : 2'b01);
        @(negedge clk);
        chk("sb_cells", cells_o, e.cells);
        chk("sb_player", player_o, e.player);
        chk("sb_count", move_count, e.cnt);
      end
    end
  end

  always @(negedge clk) if (rst_n && timeout_o) tcount++;

  task automatic move(input bit n, input bit p);
    @(posedge clk); #1;
    move_next = n; move_prev = p;
    @(posedge clk); #1;
    move_next = 0; move_prev = 0;
    if (n && !p) m_cursor = m_cursor + 4'd1;
    if (p && !n) m_cursor = m_cursor - 4'd1;
  endtask

  task automatic goto(input int target);
    for (int i = 0; i < 16 && m_cursor != target[3:0]; i++) move(1, 0);
  endtask

  task automatic do_place(input bit empty);
    exp_t e;
    e.ok = empty && (m_cnt < 16);
    if (e.ok) begin
      m_cells[m_cursor] = m_player ? 4'h2 : 4'h1;
      m_player = ~m_player;
      m_cnt++;
    end
    e.cells = m_pack(); e.player = m_player; e.cnt = m_cnt[4:0];
    sb.push_back(e);
    @(posedge clk); #1;
    place = 1; empty_i = empty;
    @(posedge clk); #1;
    place = 0;
    repeat (4) @(posedge clk);
    #1 empty_i = 0;
  endtask

  task automatic do_clear();
    @(posedge clk); #1 clear = 1;
    @(posedge clk); #1 clear = 0;
    m_reset();
  endtask

  task automatic chk_state(input string tag);
    @(negedge clk);
    chk({tag, "_counter"}, counter_o, {4'h0, m_cursor});
    chk({tag, "_cells"}, cells_o, m_pack());
    chk({tag, "_player"}, player_o, m_player);
    chk({tag, "_count"}, move_count, m_cnt[4:0]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    m_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
`ifdef TURN_TIMEOUT_EN
    for (int k = 0; k < 40; k++) @(negedge clk);
    chk("timeout_pulses", tcount, 5);
    chk("timeout_player", player_o, 1'b1);
    chk("timeout_count", move_count, 5'd0);
`else
    repeat (10) @(posedge clk);
    chk_state("reset");
    chk("reset_pulses", {place_ok, place_err, timeout_o, board_full}, 4'b0000);

    move(0, 1);
    chk_state("prev_wrap");
    chk("prev_wrap_hand", counter_o, 8'd15);
    move(1, 0); move(1, 0);
    chk_state("next_wrap");
    chk("next_wrap_hand", counter_o, 8'd1);
    move(1, 1);
    chk("both_hand", counter_o, 8'd1);

    goto(5);
    do_place(1);
    chk("place5_cell", cells_o[23:20], 4'h1);
    chk("place5_player", player_o, 1'b1);
    chk("place5_count", move_count, 5'd1);
    do_place(0);
    chk("occupied_cells", cells_o, 64'h0000_0000_0010_0000);
    chk("occupied_player", player_o, 1'b1);

    for (int c = 0; c < 16; c++) begin
      if (c != 5) begin
        goto(c);
        do_place(1);
      end
    end
    chk("full_flag", board_full, 1'b1);
    chk("full_count", move_count, 5'd16);
    chk("full_cells", cells_o, 64'h2121_2121_2112_1212);
    chk("full_player", player_o, 1'b0);
    do_place(1);
    chk_state("full_reject");

    do_clear();
    chk_state("clear");
    chk("clear_cells_hand", cells_o, 64'h0);

    goto(3);
    do_place(1);
    move(1, 0);
    @(posedge clk); #1 place = 1; empty_i = 1;
    @(posedge clk); #1 place = 0; clear = 1;
    @(posedge clk); #1 clear = 0; empty_i = 0;
    m_reset();
    repeat (4) @(posedge clk);
    chk_state("abort");
    chk("abort_hand", {counter_o, player_o, move_count}, 14'h0);
    chk("timeout_never", tcount, 0);
`endif
    repeat (3) @(posedge clk);
    chk("sb_pending", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
